// File: rtl/cf_uart_rx_deframer.sv
// cf_uart_rx_deframer: UART receive engine that oversamples rx, deframes 5..MDW data bits with optional parity and 1/2 stop bits
// Ports:
//   clk, rst_n         system clock, synchronous active-low reset
//   en, rx_en          global / receiver enable; either low aborts the frame in progress
//   rx                 asynchronous serial input
//   prescaler          tick period = prescaler+1 clk cycles
//   data_size          data bits per frame (clamped to 5..MDW)
//   parity_type        00 none, 01 odd, 10 even, 11 mark
//   stop_bits_count    0: one stop bit, 1: two stop bits
//   glitch_filter_en   use the GFLEN-tick majority-free filter on rx
//   timeout_bits       idle bit-times before timeout_flag (0 disables)
//   match_data         compare value for match_flag
//   data, data_valid   received word and its 1-clk push strobe
//   parity_err, frame_err, match_flag   per-frame pulses coincident with data_valid
//   break_flag, timeout_flag            event pulses
//   busy               receiver not in IDLE
module cf_uart_rx_deframer #(
    parameter int SC    = 8,
    parameter int MDW   = 9,
    parameter int GFLEN = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           rx_en,
    input  logic           rx,
    input  logic [15:0]    prescaler,
    input  logic [3:0]     data_size,
    input  logic [1:0]     parity_type,
    input  logic           stop_bits_count,
    input  logic           glitch_filter_en,
    input  logic [5:0]     timeout_bits,
    input  logic [MDW-1:0] match_data,
    output logic [MDW-1:0] data,
    output logic           data_valid,
    output logic           parity_err,
    output logic           frame_err,
    output logic           match_flag,
    output logic           break_flag,
    output logic           timeout_flag,
    output logic           busy
);
    localparam int SW = $clog2(SC);
    localparam int BW = $clog2(MDW + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [GFLEN-1:0] filt_q, filt_d;
    logic             rxf_q, rxf_d, rxp_q, rxp_d;
    logic [SW-1:0]    s_q, s_d, tmo_s_q, tmo_s_d;
    logic [BW-1:0]    bit_q, bit_d, dw;
    logic [MDW-1:0]   shreg_q, shreg_d, data_q, data_d;
    logic             par_q, par_d, stop1_q, stop1_d;
    logic             dv_q, dv_d, pe_q, pe_d, fe_q, fe_d, mf_q, mf_d, bf_q, bf_d, to_q, to_d;
    logic             arm_q, arm_d;
    logic [5:0]       tmo_cnt_q, tmo_cnt_d;
    logic             act, tick, rxf, mid, fin, fe;

    always_comb begin
        act     = en & rx_en;
        sync1_d = rx;
        sync2_d = sync1_q;
        tick    = act && (cnt_q == prescaler);
        cnt_d   = (!act || tick) ? '0 : cnt_q + 16'd1;
        filt_d  = tick ? {filt_q[GFLEN-2:0], sync2_q} : filt_q;
        // filtered level only moves once the whole window agrees
        rxf_d   = (&filt_d) ? 1'b1 : (~|filt_d) ? 1'b0 : rxf_q;
        rxf     = glitch_filter_en ? rxf_q : sync2_q;
        rxp_d   = tick ? rxf : rxp_q;
        dw      = (data_size < 4'd5) ? BW'(5) : ({28'd0, data_size} > MDW) ? BW'(MDW) : BW'(data_size);
        mid     = s_q == SW'(SC - 1);
        state_d   = state_q;
        s_d       = s_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        stop1_d   = stop1_q;
        data_d    = data_q;
        arm_d     = arm_q;
        tmo_s_d   = tmo_s_q;
        tmo_cnt_d = tmo_cnt_q;
        dv_d = 1'b0;
        pe_d = 1'b0;
        fe_d = 1'b0;
        mf_d = 1'b0;
        bf_d = 1'b0;
        to_d = 1'b0;
        fin  = 1'b0;
        fe   = 1'b0;
        if (!act) begin
            state_d   = IDLE;
            s_d       = '0;
            arm_d     = 1'b0;
            tmo_s_d   = '0;
            tmo_cnt_d = '0;
        end else if (tick) begin
            s_d = mid ? '0 : s_q + SW'(1);
            case (state_q)
                IDLE: begin
                    s_d = '0;
                    if (rxp_q && !rxf) begin
                        state_d   = START;
                        tmo_s_d   = '0;
                        tmo_cnt_d = '0;
                    end else if (arm_q && timeout_bits != 6'd0) begin
                        tmo_s_d = (tmo_s_q == SW'(SC - 1)) ? '0 : tmo_s_q + SW'(1);
                        if (tmo_s_q == SW'(SC - 1)) begin
                            tmo_cnt_d = tmo_cnt_q + 6'd1;
                            if (tmo_cnt_d == timeout_bits) begin
                                to_d  = 1'b1;
                                arm_d = 1'b0;
                            end
                        end
                    end
                end
                START: begin
                    // start bit is checked at its centre, half a bit after the edge
                    if (s_q == SW'(SC / 2 - 1)) begin
                        s_d     = '0;
                        state_d = rxf ? IDLE : DATA;
                        bit_d   = '0;
                        shreg_d = '0;
                    end
                end
                DATA: begin
                    if (mid) begin
                        shreg_d[bit_q] = rxf;
                        bit_d = bit_q + BW'(1);
                        if (bit_q == dw - BW'(1))
                            state_d = (parity_type != 2'b00) ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    if (mid) begin
                        par_d   = rxf;
                        state_d = STOP1;
                    end
                end
                STOP1: begin
                    if (mid) begin
                        if (shreg_q == '0 && (parity_type == 2'b00 || !par_q) && !rxf) begin
                            state_d = BRK_WAIT;
                            bf_d    = 1'b1;
                        end else if (stop_bits_count) begin
                            stop1_d = rxf;
                            state_d = STOP2;
                        end else begin
                            fin = 1'b1;
                            fe  = !rxf;
                        end
                    end
                end
                STOP2: begin
                    if (mid) begin
                        fin = 1'b1;
                        fe  = !stop1_q || !rxf;
                    end
                end
                BRK_WAIT: begin
                    s_d = '0;
                    if (rxf)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (fin) begin
                state_d   = IDLE;
                data_d    = shreg_q;
                dv_d      = 1'b1;
                fe_d      = fe;
                mf_d      = shreg_q == match_data;
                arm_d     = 1'b1;
                tmo_s_d   = '0;
                tmo_cnt_d = '0;
                pe_d      = (parity_type == 2'b01) ? ~(^shreg_q ^ par_q) :
                            (parity_type == 2'b10) ? (^shreg_q ^ par_q) :
                            (parity_type == 2'b11) ? !par_q : 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            filt_q    <= '1;
            rxf_q     <= 1'b1;
            rxp_q     <= 1'b1;
            s_q       <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            stop1_q   <= 1'b0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            mf_q      <= 1'b0;
            bf_q      <= 1'b0;
            to_q      <= 1'b0;
            arm_q     <= 1'b0;
            tmo_s_q   <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            filt_q    <= filt_d;
            rxf_q     <= rxf_d;
            rxp_q     <= rxp_d;
            s_q       <= s_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            stop1_q   <= stop1_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            mf_q      <= mf_d;
            bf_q      <= bf_d;
            to_q      <= to_d;
            arm_q     <= arm_d;
            tmo_s_q   <= tmo_s_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign data         = data_q;
    assign data_valid   = dv_q;
    assign parity_err   = pe_q;
    assign frame_err    = fe_q;
    assign match_flag   = mf_q;
    assign break_flag   = bf_q;
    assign timeout_flag = to_q;
    assign busy         = state_q != IDLE;
endmodule
